// File: rtl/llc_bus_if.sv
// rtl/llc_bus_if.sv - LLC bus-operation queue, tenure FSM and snoop-result response channel
//
// Purpose: accepts READ/WRITE/INVALIDATE/RWIM ops from the LLC into a circular
// queue, arbitrates for the system bus, drives one address-phase cycle, samples
// the snoop window and returns HIT/HITM/NOHIT over a valid/ready channel.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready/req_op/req_addr   LLC request channel (push side of queue)
//   bus_req/bus_gnt                   bus arbitration
//   bus_addr_valid/bus_op/bus_addr    address phase (one cycle per tenure)
//   snoop_hit/snoop_hitm              snoop inputs, sampled on the last SNOOP cycle
//   rsp_valid/rsp_ready/rsp_result/rsp_addr   response channel back to the LLC
//   op_count/hitm_count               statistics: tenures issued, HITM responses

module llc_bus_if #(
    parameter int ADDR_BITS  = 32,
    parameter int DEPTH      = 4,
    parameter int SNOOP_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 bus_addr_valid,
    output logic [1:0]           bus_op,
    output logic [ADDR_BITS-1:0] bus_addr,
    input  logic                 snoop_hit,
    input  logic                 snoop_hitm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_result,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [31:0]          op_count,
    output logic [31:0]          hitm_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(SNOOP_WAIT + 1);

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] RES_HIT   = 2'b00;
    localparam logic [1:0] RES_HITM  = 2'b01;
    localparam logic [1:0] RES_NOHIT = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_SNOOP, S_RESP} state_t;
    state_t r_state, w_next;

    logic [1:0]           r_q_op   [DEPTH];
    logic [ADDR_BITS-1:0] r_q_addr [DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_push, w_pop;

    logic [1:0]           r_op;
    logic [ADDR_BITS-1:0] r_addr;
    logic [SW-1:0]        r_snp_cnt;
    logic                 r_bus_req, r_bus_av, r_rsp_valid;
    logic [1:0]           r_bus_op, r_rsp_result;
    logic [ADDR_BITS-1:0] r_bus_addr, r_rsp_addr;
    logic [31:0]          r_op_count, r_hitm_count;
    logic [1:0]           w_snp_result;

    // Ready comes only from the registered count: a pop in the same cycle
    // never frees a slot for a push.
    assign req_ready    = (r_count != CW'(DEPTH));
    assign w_push       = req_valid && req_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_snp_result = snoop_hitm ? RES_HITM : (snoop_hit ? RES_HIT : RES_NOHIT);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_wr_ptr]   <= req_op;
            r_q_addr[r_wr_ptr] <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = S_ARB;
            S_ARB:   if (bus_gnt) w_next = S_ADDR;
            S_ADDR:  w_next = (r_op == OP_WRITE) ? S_RESP : S_SNOOP;
            S_SNOOP: if (r_snp_cnt == '0) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_addr       <= '0;
            r_snp_cnt    <= '0;
            r_bus_req    <= 1'b0;
            r_bus_av     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_bus_op     <= '0;
            r_bus_addr   <= '0;
            r_rsp_result <= '0;
            r_rsp_addr   <= '0;
            r_op_count   <= '0;
            r_hitm_count <= '0;
        end else begin
            r_state     <= w_next;
            // Strobes are registered copies of the next-state decode.
            r_bus_req   <= (w_next == S_ARB);
            r_bus_av    <= (w_next == S_ADDR);
            r_rsp_valid <= (w_next == S_RESP);

            if (w_pop) begin
                r_op   <= r_q_op[r_rd_ptr];
                r_addr <= r_q_addr[r_rd_ptr];
            end

            if (r_state == S_ARB && bus_gnt) begin
                r_bus_op   <= r_op;
                r_bus_addr <= r_addr;
            end

            if (r_state == S_ADDR) begin
                r_op_count <= r_op_count + 32'd1;
                r_snp_cnt  <= SW'(SNOOP_WAIT - 1);
                if (r_op == OP_WRITE) begin
                    r_rsp_result <= RES_NOHIT;
                    r_rsp_addr   <= r_addr;
                end
            end

            // Snoop lines are only looked at when the down-counter has expired.
            if (r_state == S_SNOOP) begin
                if (r_snp_cnt == '0) begin
                    r_rsp_result <= w_snp_result;
                    r_rsp_addr   <= r_addr;
                end else begin
                    r_snp_cnt <= r_snp_cnt - 1'b1;
                end
            end

            if (r_state == S_RESP && rsp_ready && r_rsp_result == RES_HITM)
                r_hitm_count <= r_hitm_count + 32'd1;
        end
    end

    assign bus_req        = r_bus_req;
    assign bus_addr_valid = r_bus_av;
    assign bus_op         = r_bus_op;
    assign bus_addr       = r_bus_addr;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp_result;
    assign rsp_addr       = r_rsp_addr;
    assign op_count       = r_op_count;
    assign hitm_count     = r_hitm_count;

endmodule

// File: tb/tb_llc_bus_if.sv
// tb/tb_llc_bus_if.sv - self-checking bench for llc_bus_if with an in-order transaction model

module tb_llc_bus_if;
    localparam int AB = 32;
    localparam int SNOOP_WAIT = 2;

    typedef struct packed { logic [1:0] op; logic [31:0] addr; } op_t;
    typedef struct packed { logic [1:0] res; logic [31:0] addr; logic [15:0] gap; } rsp_t;
    typedef struct packed { logic hit; logic hitm; } snp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AB-1:0] req_addr = '0;
    logic          bus_req;
    logic          bus_gnt = 1'b0;
    logic          bus_addr_valid;
    logic [1:0]    bus_op;
    logic [AB-1:0] bus_addr;
    logic          snoop_hit = 1'b0;
    logic          snoop_hitm = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_result;
    logic [AB-1:0] rsp_addr;
    logic [31:0]   op_count;
    logic [31:0]   hitm_count;

    llc_bus_if #(.ADDR_BITS(AB), .DEPTH(4), .SNOOP_WAIT(SNOOP_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_addr_valid(bus_addr_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .snoop_hit(snoop_hit), .snoop_hitm(snoop_hitm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_addr(rsp_addr),
        .op_count(op_count), .hitm_count(hitm_count)
    );

    always #5 clk = ~clk;

    // Stimulus configuration (written by the test sequence only)
    int   snp_mode  = 0;      // 0 random, 1 forced final + quiet, 2 forced final + noisy
    logic f_hit = 1'b0, f_hitm = 1'b0;
    int   stall_cfg = 0;
    bit   rdy_rand  = 1'b0;
    bit   gnt_rand  = 1'b0;

    // Observation state (written by the monitor only)
    op_t  acc_q[$];
    op_t  iss_q[$];
    snp_t snp_q[$];
    rsp_t rsp_q[$];
    int   cyc = 0, iss_cyc = 0, snp_k = 0, stall_used = 0, n_stall = 0;
    int   v_av_multi = 0, v_unstable = 0, v_req_rsp = 0, v_post_hs = 0;
    bit   prev_av = 0, prev_rv = 0, post_hs = 0;
    logic [1:0]  held_res;
    logic [31:0] held_addr;
    logic [15:0] first_gap = '0;

    // Checker-side state
    int cmp_cnt = 0, err_cnt = 0;
    int sb_idx = 0, sb_snp = 0, exp_hitm = 0;

    always @(negedge clk) begin
        op_t  o;
        snp_t s;
        rsp_t r;
        if (!rst_n) begin
            acc_q.delete(); iss_q.delete(); snp_q.delete(); rsp_q.delete();
            snp_k = 0; stall_used = 0; prev_av = 0; prev_rv = 0; post_hs = 0;
            v_av_multi = 0; v_unstable = 0; v_req_rsp = 0; v_post_hs = 0;
            snoop_hit = 1'b0; snoop_hitm = 1'b0;
        end else begin
            cyc++;
            if (post_hs) begin
                if (bus_req || bus_addr_valid) v_post_hs++;
                post_hs = 0;
            end
            if (req_valid && req_ready) begin
                o.op = req_op; o.addr = req_addr;
                acc_q.push_back(o);
            end
            if (snp_k == 1) begin
                if (snp_mode == 0) begin
                    s.hit = 1'($urandom_range(0, 1)); s.hitm = 1'($urandom_range(0, 1));
                end else begin
                    s.hit = f_hit; s.hitm = f_hitm;
                end
                snoop_hit = s.hit; snoop_hitm = s.hitm;
                snp_q.push_back(s);
            end else if (snp_mode == 0) begin
                snoop_hit = 1'($urandom_range(0, 1)); snoop_hitm = 1'($urandom_range(0, 1));
            end else begin
                snoop_hit = (snp_mode == 2) && (snp_k > 1);
                snoop_hitm = (snp_mode == 2) && (snp_k > 1);
            end
            if (snp_k > 0) snp_k--;
            if (bus_addr_valid) begin
                if (prev_av) v_av_multi++;
                o.op = bus_op; o.addr = bus_addr;
                iss_q.push_back(o);
                iss_cyc = cyc;
                if (bus_op != 2'b01) snp_k = SNOOP_WAIT;
            end
            if (rsp_valid && stall_used < stall_cfg) begin
                rsp_ready = 1'b0; stall_used++; n_stall++;
            end else begin
                rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rsp_valid) begin
                if (bus_req) v_req_rsp++;
                if (!prev_rv) first_gap = 16'(cyc - iss_cyc);
                else if (rsp_result !== held_res || rsp_addr !== held_addr) v_unstable++;
                held_res = rsp_result; held_addr = rsp_addr;
                if (rsp_ready) begin
                    r.res = rsp_result; r.addr = rsp_addr; r.gap = first_gap;
                    rsp_q.push_back(r);
                    post_hs = 1; stall_used = 0;
                end
            end
            prev_av = bus_addr_valid;
            prev_rv = rsp_valid && !rsp_ready;
        end
    end

    task automatic push_op(input logic [1:0] op, input logic [31:0] addr);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr;
        do begin @(negedge clk); n++; end while (!req_ready && n < 200);
        cmp_cnt++;
        if (!req_ready) begin
            err_cnt++; $display("FAIL push_timeout: req_ready %0b after %0d cycles, want 1", req_ready, n);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while (n < bound) begin
            @(posedge clk); #1;
            if (gnt_rand) bus_gnt = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_q.size() == acc_q.size() && iss_q.size() == acc_q.size()
                && !rsp_valid && !bus_req && !bus_addr_valid) break;
            n++;
        end
        cmp_cnt++;
        if (n >= bound) begin
            err_cnt++; $display("FAIL %s drain_timeout: %0d of %0d responses after %0d cycles", tag, rsp_q.size(), acc_q.size(), n);
        end
        bus_gnt = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_scoreboard(input string tag);
        op_t a; snp_t s; logic [1:0] er; logic [15:0] eg;
        for (int i = sb_idx; i < acc_q.size(); i++) begin
            a = acc_q[i];
            cmp_cnt++;
            if (i >= iss_q.size() || i >= rsp_q.size()) begin
                err_cnt++; $display("FAIL %s missing_op%0d: issued %0d responded %0d, want > %0d", tag, i, iss_q.size(), rsp_q.size(), i);
                continue;
            end
            cmp_cnt++;
            if (iss_q[i] !== a) begin
                err_cnt++; $display("FAIL %s issue%0d: got op %b addr %h, want op %b addr %h", tag, i, iss_q[i].op, iss_q[i].addr, a.op, a.addr);
            end
            if (a.op == 2'b01) begin
                er = 2'b10; eg = 16'd1;
            end else begin
                eg = 16'(SNOOP_WAIT + 1);
                cmp_cnt++;
                if (sb_snp >= snp_q.size()) begin
                    err_cnt++; $display("FAIL %s snoop_window%0d: %0d windows seen, want > %0d", tag, i, snp_q.size(), sb_snp);
                    er = 2'b11;
                end else begin
                    s = snp_q[sb_snp]; sb_snp++;
                    er = s.hitm ? 2'b01 : (s.hit ? 2'b00 : 2'b10);
                end
            end
            if (er == 2'b01) exp_hitm++;
            cmp_cnt++;
            if (rsp_q[i].res !== er || rsp_q[i].addr !== a.addr) begin
                err_cnt++; $display("FAIL %s rsp%0d: got res %b addr %h, want res %b addr %h", tag, i, rsp_q[i].res, rsp_q[i].addr, er, a.addr);
            end
            cmp_cnt++;
            if (rsp_q[i].gap !== eg) begin
                err_cnt++; $display("FAIL %s gap%0d: addr-phase to rsp_valid %0d cycles, want %0d", tag, i, rsp_q[i].gap, eg);
            end
        end
        sb_idx = acc_q.size();
        cmp_cnt++;
        if (iss_q.size() != acc_q.size() || rsp_q.size() != acc_q.size() || snp_q.size() != sb_snp) begin
            err_cnt++; $display("FAIL %s counts: issued %0d responded %0d snoops %0d, want %0d %0d %0d", tag, iss_q.size(), rsp_q.size(), snp_q.size(), acc_q.size(), acc_q.size(), sb_snp);
        end
        cmp_cnt++;
        if (op_count !== 32'(acc_q.size()) || hitm_count !== 32'(exp_hitm)) begin
            err_cnt++; $display("FAIL %s stats: op_count %0d hitm_count %0d, want %0d %0d", tag, op_count, hitm_count, acc_q.size(), exp_hitm);
        end
        cmp_cnt++;
        if (v_av_multi + v_unstable + v_req_rsp + v_post_hs != 0) begin
            err_cnt++; $display("FAIL %s protocol: multi_addr %0d unstable_rsp %0d req_during_rsp %0d no_idle_gap %0d, want all 0", tag, v_av_multi, v_unstable, v_req_rsp, v_post_hs);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_cnt++;
        if (req_ready !== 1'b1 || bus_req !== 1'b0 || bus_addr_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            err_cnt++; $display("FAIL reset_strobes: ready %b req %b av %b rv %b, want 1 0 0 0", req_ready, bus_req, bus_addr_valid, rsp_valid);
        end
        cmp_cnt++;
        if (bus_op !== 2'b00 || bus_addr !== '0 || rsp_result !== 2'b00 || rsp_addr !== '0) begin
            err_cnt++; $display("FAIL reset_data: bus_op %b bus_addr %h rsp_result %b rsp_addr %h, want all 0", bus_op, bus_addr, rsp_result, rsp_addr);
        end
        cmp_cnt++;
        if (op_count !== 32'd0 || hitm_count !== 32'd0) begin
            err_cnt++; $display("FAIL reset_counts: op_count %0d hitm_count %0d, want 0 0", op_count, hitm_count);
        end
        bus_gnt = 1'b0;
        push_op(2'b00, 32'h0000_0A00);
        push_op(2'b11, 32'h0000_0B00);
        push_op(2'b01, 32'h0000_0C00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_cnt++;
        if (req_ready !== 1'b1 || bus_req !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 32'd0) begin
            err_cnt++; $display("FAIL reset_queued: ready %b req %b rv %b op_count %0d, want 1 0 0 0", req_ready, bus_req, rsp_valid, op_count);
        end
        bus_gnt = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        cmp_cnt++;
        if (iss_q.size() != 0 || rsp_q.size() != 0 || op_count !== 32'd0) begin
            err_cnt++; $display("FAIL reset_discard: issued %0d responded %0d op_count %0d, want 0 0 0", iss_q.size(), rsp_q.size(), op_count);
        end
        sb_idx = 0; sb_snp = 0; exp_hitm = 0;
    endtask

    task automatic test_single_read;
        snp_mode = 1; f_hit = 1'b1; f_hitm = 1'b0; bus_gnt = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h0000_1A40;
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++; $display("FAIL read_accept: req_ready %b, want 1", req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (bus_req !== 1'b0) begin
            err_cnt++; $display("FAIL read_latency1: bus_req %b one cycle after accept, want 0", bus_req);
        end
        @(negedge clk);
        cmp_cnt++;
        if (bus_req !== 1'b1) begin
            err_cnt++; $display("FAIL read_latency2: bus_req %b two cycles after accept, want 1", bus_req);
        end
        wait_drain(50, "read");
        run_scoreboard("read");
        cmp_cnt++;
        if (rsp_q.size() != 1 || iss_q.size() != 1 || rsp_q[0].res !== 2'b00 || rsp_q[0].addr !== 32'h0000_1A40
            || iss_q[0].op !== 2'b00 || iss_q[0].addr !== 32'h0000_1A40 || op_count !== 32'd1) begin
            err_cnt++; $display("FAIL read_result: %0d rsps, op_count %0d, want one HIT at 00001a40 and op_count 1", rsp_q.size(), op_count);
        end
    endtask

    task automatic test_hitm;
        snp_mode = 1; f_hit = 1'b1; f_hitm = 1'b1;
        push_op(2'b11, 32'h0000_2C80);
        wait_drain(50, "hitm");
        run_scoreboard("hitm");
        cmp_cnt++;
        if (rsp_q[rsp_q.size()-1].res !== 2'b01 || hitm_count !== 32'd1) begin
            err_cnt++; $display("FAIL hitm_priority: res %b hitm_count %0d, want 01 1", rsp_q[rsp_q.size()-1].res, hitm_count);
        end
        snp_mode = 2; f_hit = 1'b0; f_hitm = 1'b0;
        push_op(2'b11, 32'h0000_2CC0);
        wait_drain(50, "early_snoop");
        run_scoreboard("early_snoop");
        cmp_cnt++;
        if (rsp_q[rsp_q.size()-1].res !== 2'b10 || hitm_count !== 32'd1) begin
            err_cnt++; $display("FAIL early_snoop_ignored: res %b hitm_count %0d, want 10 1", rsp_q[rsp_q.size()-1].res, hitm_count);
        end
    endtask

    task automatic test_write;
        snp_mode = 0;
        push_op(2'b01, 32'h0000_3F00);
        wait_drain(50, "write");
        run_scoreboard("write");
        cmp_cnt++;
        if (rsp_q[rsp_q.size()-1].res !== 2'b10 || rsp_q[rsp_q.size()-1].gap !== 16'd1) begin
            err_cnt++; $display("FAIL write_bypass: res %b gap %0d, want 10 1", rsp_q[rsp_q.size()-1].res, rsp_q[rsp_q.size()-1].gap);
        end
    endtask

    task automatic test_reset_midop;
        snp_mode = 1; f_hit = 1'b0; f_hitm = 1'b0; bus_gnt = 1'b1;
        push_op(2'b00, 32'h0000_7700);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_cnt++;
        if (bus_addr !== '0 || bus_op !== 2'b00 || rsp_addr !== '0 || op_count !== 32'd0 || hitm_count !== 32'd0) begin
            err_cnt++; $display("FAIL midop_reset: bus_addr %h rsp_addr %h op_count %0d hitm_count %0d, want all 0", bus_addr, rsp_addr, op_count, hitm_count);
        end
        repeat (10) @(posedge clk);
        #1;
        cmp_cnt++;
        if (rsp_q.size() != 0 || iss_q.size() != 0) begin
            err_cnt++; $display("FAIL midop_discard: %0d responses %0d tenures, want 0 0", rsp_q.size(), iss_q.size());
        end
        sb_idx = 0; sb_snp = 0; exp_hitm = 0;
    endtask

    task automatic test_full;
        int st0;
        snp_mode = 0; rdy_rand = 1'b0; stall_cfg = 3; bus_gnt = 1'b0;
        for (int i = 0; i < 5; i++) push_op(2'($urandom_range(0, 3)), 32'h0000_5000 + 32'(i * 'h40));
        @(negedge clk);
        cmp_cnt++;
        if (req_ready !== 1'b0 || bus_req !== 1'b1) begin
            err_cnt++; $display("FAIL full_state: req_ready %b bus_req %b, want 0 1", req_ready, bus_req);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (req_ready !== 1'b0) begin
                err_cnt++; $display("FAIL full_refuse%0d: req_ready %b, want 0", i, req_ready);
            end
        end
        @(posedge clk); #1 req_valid = 1'b0;
        st0 = n_stall;
        bus_gnt = 1'b1;
        wait_drain(300, "full");
        run_scoreboard("full");
        cmp_cnt++;
        if (op_count !== 32'd5 || n_stall - st0 != 15) begin
            err_cnt++; $display("FAIL full_complete: op_count %0d stall_cycles %0d, want 5 15", op_count, n_stall - st0);
        end
        stall_cfg = 0;
    endtask

    task automatic test_wrap;
        int r0;
        snp_mode = 0; rdy_rand = 1'b1; bus_gnt = 1'b1;
        r0 = rsp_q.size();
        for (int i = 0; i < 10; i++) push_op(2'b10, 32'((i + 1) * 'h100));
        gnt_rand = 1'b1;
        wait_drain(600, "wrap");
        gnt_rand = 1'b0;
        run_scoreboard("wrap");
        cmp_cnt++;
        if (rsp_q.size() - r0 != 10 || rsp_q[rsp_q.size()-1].addr !== 32'h0000_0A00) begin
            err_cnt++; $display("FAIL wrap_order: %0d new responses last addr %h, want 10 00000a00", rsp_q.size() - r0, rsp_q[rsp_q.size()-1].addr);
        end
    endtask

    task automatic test_random;
        snp_mode = 0; rdy_rand = 1'b1;
        for (int round = 0; round < 4; round++) begin
            bus_gnt = 1'b1;
            repeat ($urandom_range(3, 8)) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                push_op(2'($urandom_range(0, 3)), $urandom);
            end
            gnt_rand = 1'b1;
            wait_drain(800, "random");
            gnt_rand = 1'b0;
            run_scoreboard("random");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_hitm();
        test_write();
        test_reset_midop();
        test_full();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
